// File: rtl/score_keeper_if.sv
// Event strobes into and score/lives/display values out of score_keeper.
// master drives the frog event inputs; slave is the score_keeper side.
interface score_keeper_if;
  logic       i_Start;
  logic       i_Goal;
  logic       i_Hit;
  logic [5:0] o_Score;
  logic [5:0] o_Display_Score;
  logic [1:0] o_Lives;
  logic       o_Playing;
  logic       o_Game_Over;
  logic [5:0] o_High_Score;

  modport master (
    output i_Start, i_Goal, i_Hit,
    input  o_Score, o_Display_Score, o_Lives, o_Playing, o_Game_Over, o_High_Score
  );

  modport slave (
    input  i_Start, i_Goal, i_Hit,
    output o_Score, o_Display_Score, o_Lives, o_Playing, o_Game_Over, o_High_Score
  );
endinterface

// File: rtl/score_keeper.sv
// Game score/lives controller (IDLE/PLAY/DYING/GAME_OVER) feeding the score display.
// Optional high-score tracking and display alternation: SCORE_KEEPER_HIGH_SCORE_EN.
module score_keeper #(
  parameter int unsigned MAX_SCORE         = 63,
  parameter int unsigned START_LIVES       = 3,
  parameter int unsigned DEATH_HOLD_CYCLES = 25_000_000,
  parameter int unsigned HS_TOGGLE_CYCLES  = 50_000_000
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  score_keeper_if.slave bus
);

  localparam int unsigned HOLD_W = $clog2(DEATH_HOLD_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DYING, S_OVER} state_t;

  state_t            state_q, state_d;
  logic [2:0]        in_q, prev_q, ev;
  logic [5:0]        score_q, score_d;
  logic [6:0]        inc;
  logic [1:0]        lives_q, lives_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [5:0]        disp_q, disp_d;
  logic              playing_q, over_q;

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  localparam int unsigned TOG_W = $clog2(HS_TOGGLE_CYCLES + 1);
  logic [5:0]       high_q, high_d;
  logic [TOG_W-1:0] tog_q, tog_d;
  logic             sel_q, sel_d;
`endif

  // in_q is the sampled input, prev_q its history: events reach state one clock later
  assign ev  = in_q & ~prev_q;
  assign inc = {1'b0, score_q} + 7'd1;

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (ev[2]) begin
          state_d = S_PLAY;
          score_d = '0;
          lives_d = 2'(START_LIVES);
        end
      end
      S_PLAY: begin
        if (ev[0]) begin
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            hold_d  = '0;
            state_d = S_DYING;
          end else begin
            lives_d = '0;
            state_d = S_OVER;
          end
        end else if (ev[1]) begin
          score_d = (inc > 7'(MAX_SCORE)) ? 6'(MAX_SCORE) : inc[5:0];
        end
      end
      S_DYING: begin
        if (hold_q == HOLD_W'(DEATH_HOLD_CYCLES - 1)) state_d = S_PLAY;
        else                                          hold_d  = hold_q + HOLD_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  always_comb begin
    high_d = high_q;
    tog_d  = tog_q;
    sel_d  = sel_q;
    if (state_q != S_OVER && state_d == S_OVER) begin
      high_d = (score_q > high_q) ? score_q : high_q;
      tog_d  = '0;
      sel_d  = 1'b0;
    end else if (state_q == S_OVER && state_d == S_OVER) begin
      if (tog_q == TOG_W'(HS_TOGGLE_CYCLES - 1)) begin
        tog_d = '0;
        sel_d = ~sel_q;
      end else begin
        tog_d = tog_q + TOG_W'(1);
      end
    end
    disp_d = (state_d == S_OVER && sel_d) ? high_d : score_d;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      high_q <= '0;
      tog_q  <= '0;
      sel_q  <= 1'b0;
    end else begin
      high_q <= high_d;
      tog_q  <= tog_d;
      sel_q  <= sel_d;
    end
  end

  assign bus.o_High_Score = high_q;
`else
  always_comb begin
    disp_d = score_d;
  end

  assign bus.o_High_Score = '0;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= S_IDLE;
      in_q      <= '0;
      prev_q    <= '0;
      score_q   <= '0;
      lives_q   <= '0;
      hold_q    <= '0;
      disp_q    <= '0;
      playing_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_q      <= {bus.i_Start, bus.i_Goal, bus.i_Hit};
      prev_q    <= in_q;
      score_q   <= score_d;
      lives_q   <= lives_d;
      hold_q    <= hold_d;
      disp_q    <= disp_d;
      playing_q <= (state_d == S_PLAY);
      over_q    <= (state_d == S_OVER);
    end
  end

  assign bus.o_Score         = score_q;
  assign bus.o_Display_Score = disp_q;
  assign bus.o_Lives         = lives_q;
  assign bus.o_Playing       = playing_q;
  assign bus.o_Game_Over     = over_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: game-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized play.
module tb_score_keeper;

  localparam int D   = 4;
  localparam int HS  = 8;
  localparam int MAX = 63;
  localparam int SL  = 3;
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  score_keeper_if bus ();

  score_keeper #(
    .MAX_SCORE(MAX),
    .START_LIVES(SL),
    .DEATH_HOLD_CYCLES(D),
    .HS_TOGGLE_CYCLES(HS)
  ) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: game phase, lives, score, remaining hold clocks, clocks spent over
  localparam int M_IDLE = 0, M_PLAY = 1, M_DYING = 2, M_OVER = 3;
  int m_mode, m_score, m_lives, m_left, m_over_clk, m_high;
  bit s_s, s_g, s_h, p_s, p_g, p_h;

  always @(posedge clk or negedge rst_n) begin
    bit es, eg, eh;
    if (!rst_n) begin
      m_mode = M_IDLE; m_score = 0; m_lives = 0; m_left = 0; m_over_clk = 0; m_high = 0;
      s_s = 0; s_g = 0; s_h = 0; p_s = 0; p_g = 0; p_h = 0;
    end else begin
      es = s_s & !p_s; eg = s_g & !p_g; eh = s_h & !p_h;
      p_s = s_s; p_g = s_g; p_h = s_h;
      s_s = bus.i_Start; s_g = bus.i_Goal; s_h = bus.i_Hit;
      case (m_mode)
        M_IDLE: if (es) begin m_mode = M_PLAY; m_score = 0; m_lives = SL; end
        M_PLAY: begin
          if (eh) begin
            if (m_lives > 1) begin m_lives--; m_mode = M_DYING; m_left = D; end
            else begin
              m_lives = 0; m_mode = M_OVER; m_over_clk = 0;
              if (HS_EN && m_score > m_high) m_high = m_score;
            end
          end else if (eg) begin
            m_score = (m_score + 1 > MAX) ? MAX : m_score + 1;
          end
        end
        M_DYING: begin m_left--; if (m_left == 0) m_mode = M_PLAY; end
        default: begin
          m_over_clk++;
          if (es) begin m_mode = M_PLAY; m_score = 0; m_lives = SL; end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    int exp_disp;
    exp_disp = (HS_EN && m_mode == M_OVER && ((m_over_clk / HS) % 2) == 1) ? m_high : m_score;
    check("score",     int'(bus.o_Score),         m_score);
    check("display",   int'(bus.o_Display_Score), exp_disp);
    check("lives",     int'(bus.o_Lives),         m_lives);
    check("playing",   int'(bus.o_Playing),       int'(m_mode == M_PLAY));
    check("game_over", int'(bus.o_Game_Over),     int'(m_mode == M_OVER));
    check("high",      int'(bus.o_High_Score),    m_high);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.i_Start = 1'b1; tick(1); bus.i_Start = 1'b0; tick(2);
  endtask

  task automatic pulse_goal();
    bus.i_Goal = 1'b1; tick(1); bus.i_Goal = 1'b0; tick(1);
  endtask

  task automatic hit_and_recover();
    bus.i_Hit = 1'b1; tick(1); bus.i_Hit = 1'b0; tick(D + 3);
  endtask

  task automatic hit_until_over(input string name);
    int n;
    n = 0;
    while (bus.o_Game_Over !== 1'b1 && n < 6) begin
      bus.i_Hit = 1'b1; tick(1); bus.i_Hit = 1'b0;
      for (int w = 0; w < D + 4 && bus.o_Game_Over !== 1'b1; w++) tick(1);
      n++;
    end
    check(name, int'(bus.o_Game_Over), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(1);
  endtask

  initial begin
    int n;
    bus.i_Start = 1'b0; bus.i_Goal = 1'b0; bus.i_Hit = 1'b0;
    tick(2);
    check("rst_score", int'(bus.o_Score), 0);
    check("rst_lives", int'(bus.o_Lives), 0);
    check("rst_playing", int'(bus.o_Playing), 0);
    rst_n = 1'b1; tick(1);

    pulse_start();
    check("start_playing", int'(bus.o_Playing), 1);
    check("start_lives", int'(bus.o_Lives), 3);
    for (int k = 1; k <= 5; k++) begin
      bus.i_Goal = 1'b1; tick(1);
      check("goal_not_yet", int'(bus.o_Score), k - 1);
      bus.i_Goal = 1'b0; tick(1);
      check("goal_landed", int'(bus.o_Score), k);
    end

    bus.i_Goal = 1'b1; tick(20); bus.i_Goal = 1'b0; tick(2);
    check("held_goal", int'(bus.o_Score), 6);

    bus.i_Goal = 1'b1; bus.i_Hit = 1'b1; tick(1);
    bus.i_Goal = 1'b0; bus.i_Hit = 1'b0; tick(1);
    check("goalhit_score", int'(bus.o_Score), 6);
    check("goalhit_lives", int'(bus.o_Lives), 2);
    n = 1;
    for (int w = 0; w < 20; w++) begin
      bus.i_Goal = (n == 1);
      tick(1);
      if (bus.o_Playing === 1'b0) n++;
      else break;
    end
    bus.i_Goal = 1'b0;
    check("dying_clocks", n, D);
    tick(2);
    check("dying_goal_ignored", int'(bus.o_Score), 6);

    hit_and_recover();
    check("lives_after_hit", int'(bus.o_Lives), 1);
    hit_until_over("over_t4");
    check("over_lives", int'(bus.o_Lives), 0);
    pulse_start();
    check("restart_score", int'(bus.o_Score), 0);
    check("restart_lives", int'(bus.o_Lives), 3);
    for (int k = 0; k < 70; k++) pulse_goal();
    check("saturate", int'(bus.o_Score), 63);

    do_reset();
    pulse_start();
    for (int k = 0; k < 12; k++) pulse_goal();
    hit_until_over("over_g1");
    pulse_start();
    for (int k = 0; k < 7; k++) pulse_goal();
    hit_until_over("over_g2");
    check("high_after_two", int'(bus.o_High_Score), HS_EN ? 12 : 0);
    for (int k = 0; k < 4 * HS; k++) begin
      check("display_alt", int'(bus.o_Display_Score), (HS_EN && ((k / HS) % 2) == 1) ? 12 : 7);
      tick(1);
    end

    pulse_start();
    bus.i_Hit = 1'b1; tick(1); bus.i_Hit = 1'b0; tick(2);
    #3 rst_n = 1'b0;
    #1;
    check("arst_score", int'(bus.o_Score), 0);
    check("arst_lives", int'(bus.o_Lives), 0);
    check("arst_playing", int'(bus.o_Playing), 0);
    check("arst_display", int'(bus.o_Display_Score), 0);
    tick(2); rst_n = 1'b1; tick(1);
    for (int k = 0; k < 3; k++) pulse_goal();
    check("idle_goal_ignored", int'(bus.o_Score), 0);
    check("idle_not_playing", int'(bus.o_Playing), 0);
    pulse_start();
    check("post_rst_start", int'(bus.o_Playing), 1);

    for (int c = 0; c < 3000; c++) begin
      bus.i_Start = ($urandom_range(99) < 4);
      bus.i_Goal  = ($urandom_range(99) < 35);
      bus.i_Hit   = ($urandom_range(99) < 5);
      tick(1);
    end
    bus.i_Start = 1'b0; bus.i_Goal = 1'b0; bus.i_Hit = 1'b0;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
